// File: rtl/nios_btn_pkg.sv
// rtl/nios_btn_pkg.sv - shared types and constants for the pushbutton scanner
package nios_btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_CAP   = 2'd1,
    ST_WAIT_CAP = 2'd2,
    ST_CLR      = 2'd3
  } scan_state_e;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  // Index width for n buttons; a single button still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nios_btn_evt_fifo.sv
// rtl/nios_btn_evt_fifo.sv - synchronous event FIFO holding button indices
module nios_btn_evt_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Next-state: a push is refused whenever full, even if a pop frees a slot this cycle.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    pop_data = empty ? '0 : mem_q[rd_ptr_q];
    count    = count_q;
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/nios_button_scanner.sv
// rtl/nios_button_scanner.sv - round-robin edge-capture scanner for pushbutton PIO slaves
module nios_button_scanner
  import nios_btn_pkg::*;
#(
  parameter int  NUM_BTN    = 4,
  parameter int  SCAN_DIV   = 50000,
  parameter int  FIFO_DEPTH = 4,
  localparam int IDW        = id_width(NUM_BTN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    scan_en,
  output logic [NUM_BTN-1:0]      btn_chipselect,
  output logic [1:0]              btn_address,
  output logic                    btn_write_n,
  output logic [31:0]             btn_writedata,
  input  logic [32*NUM_BTN-1:0]   btn_readdata,
  output logic                    evt_valid,
  output logic [IDW-1:0]          evt_id,
  input  logic                    evt_ready,
  output logic                    irq,
  output logic                    busy
);

  localparam int PSW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  scan_state_e          state_q, state_d;
  logic [IDW-1:0]       idx_q, idx_d;
  logic [PSW-1:0]       presc_q, presc_d;
  logic [NUM_BTN-1:0]   cs_q, cs_d;
  logic [1:0]           addr_q, addr_d;
  logic                 wr_n_q, wr_n_d;
  logic                 tick;
  logic                 cap_bit;
  logic                 last_btn;
  logic                 advance;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;
  logic                 readdata_unused;

  // Only bit 0 of each slave's capture register matters; the rest is folded away here.
  assign readdata_unused = ^btn_readdata;

  // Prescaler: free-runs while enabled, parked at zero otherwise, ticks on its last count.
  always_comb begin
    tick    = scan_en && (presc_q == PSW'(SCAN_DIV - 1));
    presc_d = presc_q;
    if (!scan_en || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PSW'(1);
    end
  end

  // Scan sequencer: next state, index and the registered bus strobes for that state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    push     = 1'b0;
    advance  = 1'b0;
    cap_bit  = 1'b0;
    last_btn = (idx_q == IDW'(NUM_BTN - 1));
    for (int i = 0; i < NUM_BTN; i++) begin
      if (idx_q == IDW'(i)) cap_bit = btn_readdata[32*i];
    end

    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (tick) state_d = ST_RD_CAP;
      end
      ST_RD_CAP: state_d = ST_WAIT_CAP;
      ST_WAIT_CAP: begin
        // A set capture with a full FIFO parks here and re-reads until room appears.
        if (!cap_bit) advance = 1'b1;
        else if (!fifo_full) state_d = ST_CLR;
      end
      ST_CLR: begin
        push    = 1'b1;
        advance = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (last_btn) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        state_d = ST_RD_CAP;
        idx_d   = idx_q + IDW'(1);
      end
    end

    cs_d = '0;
    if (state_d == ST_RD_CAP || state_d == ST_CLR) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (idx_d == IDW'(i)) cs_d[i] = 1'b1;
      end
    end
    addr_d = (state_d == ST_IDLE) ? PIO_ADDR_DATA : PIO_ADDR_EDGE;
    wr_n_d = (state_d != ST_CLR);
  end

  // State, index, prescaler and bus output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      presc_q <= '0;
      cs_q    <= '0;
      addr_q  <= PIO_ADDR_DATA;
      wr_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      wr_n_q  <= wr_n_d;
    end
  end

  nios_btn_evt_fifo #(
    .WIDTH (IDW),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (idx_q),
    .pop       (evt_ready),
    .pop_data  (evt_id),
    .count     (fifo_count_unused),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign btn_chipselect = cs_q;
  assign btn_address    = addr_q;
  assign btn_write_n    = wr_n_q;
  assign btn_writedata  = 32'h0;
  assign evt_valid      = !fifo_empty;
  assign irq            = !fifo_empty;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nios_button_scanner.sv
// tb/tb_nios_button_scanner.sv - directed bench for the pushbutton scanner
module tb_nios_button_scanner;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         scan_en = 1'b0;
  logic [3:0]   btn_chipselect;
  logic [1:0]   btn_address;
  logic         btn_write_n;
  logic [31:0]  btn_writedata;
  logic [127:0] btn_readdata = '0;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_ready = 1'b0;
  logic         irq;
  logic         busy;

  logic [3:0]   cap = 4'b0;
  logic [3:0]   inj = 4'b0;
  logic [3:0]   rd_log [$];
  logic [3:0]   wr_log [$];
  logic [1:0]   wr_addr_log [$];
  int           cyc = 0;
  int           wr_cyc = 0;
  int           vld_cyc = 0;
  logic         prev_valid = 1'b0;
  int           errors = 0;
  int           checks = 0;

  nios_button_scanner #(
    .NUM_BTN    (4),
    .SCAN_DIV   (20),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .scan_en        (scan_en),
    .btn_chipselect (btn_chipselect),
    .btn_address    (btn_address),
    .btn_write_n    (btn_write_n),
    .btn_writedata  (btn_writedata),
    .btn_readdata   (btn_readdata),
    .evt_valid      (evt_valid),
    .evt_id         (evt_id),
    .evt_ready      (evt_ready),
    .irq            (irq),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // PIO slave models: readdata registered from the shared address, clear beats a new edge.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (btn_address == 2'd3) btn_readdata[32*i +: 32] <= {31'h2AAAAAAA, cap[i]};
      else btn_readdata[32*i +: 32] <= {31'h15555555, 1'b1};
      if (btn_chipselect[i] && btn_address == 2'd3 && !btn_write_n) cap[i] <= 1'b0;
      else if (inj[i]) cap[i] <= 1'b1;
    end
  end

  // Bus and event monitor.
  always @(negedge clk) begin
    cyc++;
    if (btn_chipselect != 4'b0 && btn_write_n) rd_log.push_back(btn_chipselect);
    if (!btn_write_n) begin
      wr_log.push_back(btn_chipselect);
      wr_addr_log.push_back(btn_address);
      wr_cyc = cyc;
    end
    if (evt_valid && !prev_valid) vld_cyc = cyc;
    prev_valid = evt_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic inject(input logic [3:0] m);
    @(negedge clk) inj = m;
    @(negedge clk) inj = 4'b0;
  endtask

  task automatic pop_one();
    @(negedge clk) evt_ready = 1'b1;
    @(negedge clk) evt_ready = 1'b0;
  endtask

  task automatic wait_pass(output int len, output longint t_rise);
    int n = 0;
    t_rise = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      len = -1;
      return;
    end
    t_rise = $time;
    len = 0;
    while (busy && len < 200) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (btn_chipselect !== 4'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0000", btn_chipselect); end
    checks++; if (btn_address !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", btn_address); end
    checks++; if (btn_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b expected 1", btn_write_n); end
    checks++; if (btn_writedata !== 32'h0) begin errors++; $display("FAIL reset_writedata: got %h expected 0", btn_writedata); end
    checks++; if (evt_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_evt: got valid=%b irq=%b expected 0 0", evt_valid, irq); end
    checks++; if (evt_id !== 2'd0) begin errors++; $display("FAIL reset_evt_id: got %0d expected 0", evt_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    int l1, l2;
    longint t1, t2;
    logic [3:0] exp_cs [4];
    exp_cs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    @(negedge clk);
    rd_log.delete();
    wr_log.delete();
    scan_en = 1'b1;
    wait_pass(l1, t1);
    checks++; if (l1 !== 8) begin errors++; $display("FAIL idle_pass_len: got %0d expected 8", l1); end
    wait_pass(l2, t2);
    checks++; if (l2 !== 8) begin errors++; $display("FAIL idle_pass_len2: got %0d expected 8", l2); end
    checks++; if (t2 - t1 !== 64'd200) begin errors++; $display("FAIL idle_period: got %0d expected 200", t2 - t1); end
    checks++; if (rd_log.size() !== 8) begin errors++; $display("FAIL idle_rd_count: got %0d expected 8", rd_log.size()); end
    for (int i = 0; i < 8 && i < rd_log.size(); i++) begin
      checks++; if (rd_log[i] !== exp_cs[i % 4]) begin errors++; $display("FAIL idle_rd_cs[%0d]: got %b expected %b", i, rd_log[i], exp_cs[i % 4]); end
    end
    checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL idle_writes: got %0d expected 0", wr_log.size()); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL idle_irq: got %b expected 0", irq); end
  endtask

  task automatic test_single_capture();
    int l;
    longint t;
    wr_log.delete();
    wr_addr_log.delete();
    inject(4'b0100);
    wait_pass(l, t);
    checks++; if (l !== 9) begin errors++; $display("FAIL single_pass_len: got %0d expected 9", l); end
    checks++; if (wr_log.size() !== 1) begin errors++; $display("FAIL single_write_count: got %0d expected 1", wr_log.size()); end
    if (wr_log.size() > 0) begin
      checks++; if (wr_log[0] !== 4'b0100) begin errors++; $display("FAIL single_write_cs: got %b expected 0100", wr_log[0]); end
      checks++; if (wr_addr_log[0] !== 2'd3) begin errors++; $display("FAIL single_write_addr: got %0d expected 3", wr_addr_log[0]); end
    end
    checks++; if (vld_cyc - wr_cyc !== 1) begin errors++; $display("FAIL single_evt_latency: got %0d expected 1", vld_cyc - wr_cyc); end
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin errors++; $display("FAIL single_evt: got valid=%b id=%0d expected 1 2", evt_valid, evt_id); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b expected 1", irq); end
    checks++; if (cap !== 4'b0) begin errors++; $display("FAIL single_cleared: got %b expected 0000", cap); end
    pop_one();
    checks++; if (evt_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL single_pop: got valid=%b irq=%b expected 0 0", evt_valid, irq); end
  endtask

  task automatic test_two_captures();
    int l;
    longint t;
    inject(4'b1010);
    wait_pass(l, t);
    checks++; if (l !== 10) begin errors++; $display("FAIL two_pass_len: got %0d expected 10", l); end
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin errors++; $display("FAIL two_first: got valid=%b id=%0d expected 1 1", evt_valid, evt_id); end
    pop_one();
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin errors++; $display("FAIL two_second: got valid=%b id=%0d expected 1 3", evt_valid, evt_id); end
    pop_one();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL two_empty: got %b expected 0", evt_valid); end
  endtask

  task automatic test_fifo_full();
    int l, n;
    longint t;
    logic [1:0] exp_ids [4];
    exp_ids = '{2'd1, 2'd2, 2'd3, 2'd0};
    wr_log.delete();
    inject(4'b1111);
    wait_pass(l, t);
    checks++; if (l !== 12) begin errors++; $display("FAIL full_pass_len: got %0d expected 12", l); end
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin errors++; $display("FAIL full_head: got valid=%b id=%0d expected 1 0", evt_valid, evt_id); end
    inject(4'b0001);
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_stall_busy: got %b expected 1", busy); end
    checks++; if (cap[0] !== 1'b1) begin errors++; $display("FAIL full_capture_kept: got %b expected 1", cap[0]); end
    checks++; if (wr_log.size() !== 4) begin errors++; $display("FAIL full_no_clear: got %0d writes expected 4", wr_log.size()); end
    pop_one();
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_resume: got busy=%b expected 0", busy); end
    checks++; if (wr_log.size() !== 5) begin errors++; $display("FAIL full_fifth_clear: got %0d writes expected 5", wr_log.size()); end
    if (wr_log.size() > 4) begin
      checks++; if (wr_log[4] !== 4'b0001) begin errors++; $display("FAIL full_fifth_cs: got %b expected 0001", wr_log[4]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_id !== exp_ids[i]) begin errors++; $display("FAIL full_order[%0d]: got valid=%b id=%0d expected 1 %0d", i, evt_valid, evt_id, exp_ids[i]); end
      pop_one();
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", evt_valid); end
  endtask

  task automatic test_reset_in_clr();
    int l, n;
    longint t;
    inject(4'b0100);
    n = 0;
    while (btn_write_n !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (btn_write_n !== 1'b0) begin errors++; $display("FAIL rst_clr_reach: got write_n=%b expected 0", btn_write_n); end
    reset_n = 1'b0;
    #1;
    checks++; if (btn_chipselect !== 4'b0 || btn_address !== 2'd0 || btn_write_n !== 1'b1) begin errors++; $display("FAIL rst_clr_bus: got cs=%b addr=%0d wn=%b expected 0000 0 1", btn_chipselect, btn_address, btn_write_n); end
    checks++; if (busy !== 1'b0 || evt_valid !== 1'b0 || irq !== 1'b0 || evt_id !== 2'd0) begin errors++; $display("FAIL rst_clr_evt: got busy=%b valid=%b irq=%b id=%0d expected 0 0 0 0", busy, evt_valid, irq, evt_id); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_clr_fifo_empty: got %b expected 0", evt_valid); end
    checks++; if (cap[2] !== 1'b1) begin errors++; $display("FAIL rst_clr_pending: got %b expected 1", cap[2]); end
    wait_pass(l, t);
    checks++; if (l !== 9) begin errors++; $display("FAIL rst_clr_repass_len: got %0d expected 9", l); end
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin errors++; $display("FAIL rst_clr_refound: got valid=%b id=%0d expected 1 2", evt_valid, evt_id); end
    pop_one();
  endtask

  task automatic test_scan_en_drop();
    int l, n;
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    l = 0;
    while (busy && l < 100) begin
      l++;
      if (l == 3) scan_en = 1'b0;
      @(negedge clk);
    end
    checks++; if (l !== 8) begin errors++; $display("FAIL drop_pass_len: got %0d expected 8", l); end
    rd_log.delete();
    repeat (60) @(negedge clk);
    checks++; if (rd_log.size() !== 0) begin errors++; $display("FAIL drop_no_strobes: got %0d expected 0", rd_log.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_capture();
    test_two_captures();
    test_fifo_full();
    test_reset_in_clr();
    test_scan_en_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
